read_priority_defer: RTL and testbench
======================================

Name: read_priority_defer

Overview:
- Read-side arbiter for a single-read-port data memory shared by ALU operand reads and local (I/O / addressing-unit) reads.
- ALU reads always win the port.
- A colliding local read is not dropped. It is queued in a small in-order defer FIFO and issued on the next cycle the ALU leaves the port idle.
- Tracks the memory read latency and returns each read's data to its requester with a valid strobe.

Parameters:
- WORD_WIDTH, 36, width of a memory word.
- ADDR_WIDTH, 10, width of a read address.
- DEFER_DEPTH, 4, number of entries in the local-read defer FIFO; must be a power of 2, at least 2.
- DEFER_PTR_WIDTH, 2, log2(DEFER_DEPTH).
- RAM_READ_LATENCY, 2, cycles from mem_rden to valid mem_read_data; at least 1.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- ALU_rden  in  1  ALU read request, one per cycle, never stalled.
- ALU_read_addr  in  ADDR_WIDTH  ALU read address.
- ALU_read_data  out  WORD_WIDTH  returned data for ALU reads.
- ALU_read_valid  out  1  ALU_read_data valid this cycle.
- local_rden  in  1  local read request.
- local_read_addr  in  ADDR_WIDTH  local read address.
- local_read_ready  out  1  local request accepted this cycle.
- local_read_data  out  WORD_WIDTH  returned data for local reads.
- local_read_valid  out  1  local_read_data valid this cycle.
- mem_rden  out  1  memory read enable.
- mem_read_addr  out  ADDR_WIDTH  memory read address.
- mem_read_data  in  WORD_WIDTH  memory read data, RAM_READ_LATENCY after issue.

Behaviour:
- Reset state, while reset_n=0 at a clock edge:
  - defer FIFO empty, pointers 0, count 0;
  - tag pipeline cleared;
  - ALU_read_valid, local_read_valid and mem_rden are 0 in the cycle after reset is sampled;
  - local_read_ready=0 while reset_n=0.
- Reset mid-operation: in-flight reads and queued local reads are discarded; no valid is ever produced for them.
- Port selection (combinational, priority order, evaluated each cycle):
  1. ALU_rden=1: issue ALU_read_addr, source=ALU.
  2. Otherwise, if the FIFO is not empty: issue the FIFO head, source=LOCAL, pop.
  3. Otherwise, if local_rden=1: issue local_read_addr directly (bypass, zero added latency), source=LOCAL.
  4. Otherwise: mem_rden=0.
- mem_rden = 1 whenever a source is selected.
- local_read_ready = (FIFO count != DEFER_DEPTH). It is conservative: it stays 0 when full even if a pop occurs that cycle.
- Local request is accepted when local_rden=1 and local_read_ready=1.
  - Accepted, and not bypassed under rule 3: pushed to the FIFO tail.
  - Request while ready=0: ignored; the requester must hold and retry.
- Simultaneous push and pop (FIFO non-empty, ALU idle, new local request): head issues, new request is pushed, count unchanged.
- Ordering:
  - local reads complete strictly in acceptance order;
  - ALU reads complete in issue order;
  - a local read is never bypassed around queued entries.
- Pointers wrap modulo DEFER_DEPTH.
- Count is DEFER_PTR_WIDTH+1 bits wide, ranging 0..DEFER_DEPTH.
- Tag pipeline: RAM_READ_LATENCY stages of {valid, source}, shifted every cycle. Stage 0 is loaded with {mem_rden, selected source}.
- Response, at pipeline output:
  - ALU_read_valid = valid & (source==ALU);
  - local_read_valid = valid & (source==LOCAL);
  - ALU_read_data and local_read_data both driven directly from mem_read_data, meaningful only while the matching valid is high;
  - at most one valid is high per cycle.
- Latency:
  - ALU read: exactly RAM_READ_LATENCY cycles;
  - local read: RAM_READ_LATENCY + cycles spent in the FIFO.
- Starvation: continuous ALU_rden starves local reads indefinitely. Accepted by design, because threads never read every cycle.

Optional Feature:
- Macro: READ_DEFER_STATS_EN.
- With the macro defined, the block adds the following:
  - Output defer_stall_count (16 bits): saturating count of cycles with local_rden=1 and local_read_ready=0. Holds at 16'hFFFF.
  - Output defer_max_occupancy (DEFER_PTR_WIDTH+1 bits): high-water mark of FIFO count.
  - Both outputs clear to 0 on reset.
- Without the macro: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- ALU only: ALU_rden=1, addr 0x010 for 1 cycle -> mem_rden=1, mem_read_addr=0x010 same cycle; ALU_read_valid=1 exactly 2 cycles later with mem_read_data; local_read_valid stays 0.
- Local bypass: ALU idle, FIFO empty, local read 0x020 -> issued same cycle; local_read_valid 2 cycles later; FIFO count stays 0.
- Collision: ALU 0x030 and local 0x040 in the same cycle, ALU idle next cycle -> 0x030 issued in cycle N, 0x040 in N+1; ALU_read_valid at N+2, local_read_valid at N+3.
- Full: ALU_rden=1 for 6 cycles while local requests 0x100..0x105 are presented every cycle:
  - 0x100..0x103 queued; ready drops to 0 after 4 accepts;
  - 0x104 is held until accepted;
  - after ALU stops, local data returns in order 0x100, 0x101, 0x102, 0x103, 0x104, 0x105;
  - with READ_DEFER_STATS_EN defined: defer_max_occupancy=4 and defer_stall_count>0.
- Reset mid-flight: 3 entries queued plus 2 in-flight reads, reset_n=0 for 1 cycle -> no valids afterwards; count=0; next local read bypasses.
- Push/pop same cycle: FIFO holds 0x200, ALU idle, new local 0x201 -> 0x200 issued, 0x201 queued, count stays 1; 0x201 issued next cycle.

Source files
------------

// File: rtl/read_priority_defer.sv
// rtl/read_priority_defer.sv - ALU-priority read arbiter with in-order local read defer FIFO
// Optional statistics outputs (defer_stall_count, defer_max_occupancy) exist only when
// READ_DEFER_STATS_EN is defined.
module read_priority_defer #(
  parameter int WORD_WIDTH       = 36,
  parameter int ADDR_WIDTH       = 10,
  parameter int DEFER_DEPTH      = 4,
  parameter int DEFER_PTR_WIDTH  = 2,
  parameter int RAM_READ_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       ALU_rden,
  input  logic [ADDR_WIDTH-1:0]      ALU_read_addr,
  output logic [WORD_WIDTH-1:0]      ALU_read_data,
  output logic                       ALU_read_valid,
  input  logic                       local_rden,
  input  logic [ADDR_WIDTH-1:0]      local_read_addr,
  output logic                       local_read_ready,
  output logic [WORD_WIDTH-1:0]      local_read_data,
  output logic                       local_read_valid,
  output logic                       mem_rden,
  output logic [ADDR_WIDTH-1:0]      mem_read_addr,
  input  logic [WORD_WIDTH-1:0]      mem_read_data
`ifdef READ_DEFER_STATS_EN
  ,
  output logic [15:0]                defer_stall_count,
  output logic [DEFER_PTR_WIDTH:0]   defer_max_occupancy
`endif
);

  localparam logic [DEFER_PTR_WIDTH:0]   FULL_COUNT = (DEFER_PTR_WIDTH+1)'(DEFER_DEPTH);
  localparam logic [DEFER_PTR_WIDTH:0]   COUNT_ONE  = (DEFER_PTR_WIDTH+1)'(1);
  localparam logic [DEFER_PTR_WIDTH-1:0] PTR_ONE    = DEFER_PTR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]      defer_mem [DEFER_DEPTH];
  logic [DEFER_PTR_WIDTH-1:0] wr_ptr;
  logic [DEFER_PTR_WIDTH-1:0] rd_ptr;
  logic [DEFER_PTR_WIDTH:0]   count;
  logic                       fifo_empty;
  logic                       sel_alu;
  logic                       sel_fifo;
  logic                       sel_bypass;
  logic                       push;
  logic                       pop;
  logic [RAM_READ_LATENCY-1:0] tag_valid;
  logic [RAM_READ_LATENCY-1:0] tag_local;

  // Ready is conservative: a full FIFO refuses even in a cycle where it pops.
  assign fifo_empty       = (count == '0);
  assign local_read_ready = reset_n && (count != FULL_COUNT);

  // ALU first, then the oldest deferred local read, then a direct local bypass.
  assign sel_alu    = reset_n && ALU_rden;
  assign sel_fifo   = reset_n && !ALU_rden && !fifo_empty;
  assign sel_bypass = reset_n && !ALU_rden && fifo_empty && local_rden;
  assign pop        = sel_fifo;
  assign push       = local_rden && local_read_ready && !sel_bypass;
  assign mem_rden   = sel_alu || sel_fifo || sel_bypass;

  // Memory address mux following the selected source.
  always_comb begin
    mem_read_addr = ALU_read_addr;
    if (sel_fifo) begin
      mem_read_addr = defer_mem[rd_ptr];
    end else if (sel_bypass) begin
      mem_read_addr = local_read_addr;
    end
  end

  // Defer FIFO pointers and occupancy; reset discards queued local reads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) begin
        count <= count + COUNT_ONE;
      end else if (pop && !push) begin
        count <= count - COUNT_ONE;
      end
    end
  end

  // Defer FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clock) begin
    if (push) defer_mem[wr_ptr] <= local_read_addr;
  end

  // Tag pipeline tracking which requester owns each in-flight read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_local <= '0;
    end else begin
      tag_valid[0] <= mem_rden;
      tag_local[0] <= sel_fifo || sel_bypass;
      for (int i = 1; i < RAM_READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_local[i] <= tag_local[i-1];
      end
    end
  end

  // Responses: data bus shared, valids steered by the tag leaving the pipeline.
  assign ALU_read_valid   = reset_n && tag_valid[RAM_READ_LATENCY-1] && !tag_local[RAM_READ_LATENCY-1];
  assign local_read_valid = reset_n && tag_valid[RAM_READ_LATENCY-1] &&  tag_local[RAM_READ_LATENCY-1];
  assign ALU_read_data    = mem_read_data;
  assign local_read_data  = mem_read_data;

`ifdef READ_DEFER_STATS_EN
  // Saturating stall counter and FIFO high-water mark.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      defer_stall_count   <= '0;
      defer_max_occupancy <= '0;
    end else begin
      if (local_rden && !local_read_ready && (defer_stall_count != 16'hFFFF)) begin
        defer_stall_count <= defer_stall_count + 16'd1;
      end
      if (count > defer_max_occupancy) begin
        defer_max_occupancy <= count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_priority_defer.sv
// tb/tb_read_priority_defer.sv - self-checking bench for read_priority_defer
module tb_read_priority_defer;
  localparam int W = 36;
  localparam int A = 10;
  localparam int D = 4;
  localparam int P = 2;
  localparam int L = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ALU_rden;
  logic [A-1:0] ALU_read_addr;
  logic [W-1:0] ALU_read_data;
  logic         ALU_read_valid;
  logic         local_rden;
  logic [A-1:0] local_read_addr;
  logic         local_read_ready;
  logic [W-1:0] local_read_data;
  logic         local_read_valid;
  logic         mem_rden;
  logic [A-1:0] mem_read_addr;
  logic [W-1:0] mem_read_data;
`ifdef READ_DEFER_STATS_EN
  logic [15:0]  defer_stall_count;
  logic [P:0]   defer_max_occupancy;
`endif

  always #5 clock = ~clock;

  read_priority_defer #(
    .WORD_WIDTH(W), .ADDR_WIDTH(A), .DEFER_DEPTH(D), .DEFER_PTR_WIDTH(P), .RAM_READ_LATENCY(L)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .ALU_rden(ALU_rden), .ALU_read_addr(ALU_read_addr),
    .ALU_read_data(ALU_read_data), .ALU_read_valid(ALU_read_valid),
    .local_rden(local_rden), .local_read_addr(local_read_addr),
    .local_read_ready(local_read_ready), .local_read_data(local_read_data),
    .local_read_valid(local_read_valid),
    .mem_rden(mem_rden), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
`ifdef READ_DEFER_STATS_EN
    , .defer_stall_count(defer_stall_count), .defer_max_occupancy(defer_max_occupancy)
`endif
  );

  // RAM stand-in: word content is a fixed function of the address, L cycles late.
  function automatic logic [W-1:0] ram_word(input logic [A-1:0] a);
    return {16'hA5C3, 10'h000, a};
  endfunction

  logic [A-1:0] ram_pipe [L];
  always @(posedge clock) begin
    ram_pipe[0] <= mem_read_addr;
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mem_read_data = ram_word(ram_pipe[L-1]);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of waiting local addresses and a queue of responses due.
  typedef struct packed {
    logic         v;
    logic         loc;
    logic [A-1:0] addr;
  } resp_t;

  logic [A-1:0] pend_q[$];
  resp_t        resp_q[$];
  logic [A-1:0] local_log[$];
  int           m_stall = 0;
  int           m_max = 0;

  initial begin
    resp_t blank;
    blank = '0;
    for (int i = 0; i < L; i++) resp_q.push_back(blank);
  end

  always @(negedge clock) begin : compare
    logic         e_ready, e_rden, e_loc, e_pop, e_bypass;
    logic [A-1:0] e_addr;
    resp_t        head, nxt;
    e_ready  = reset_n && (pend_q.size() != D);
    e_rden   = 1'b0;
    e_loc    = 1'b0;
    e_pop    = 1'b0;
    e_bypass = 1'b0;
    e_addr   = '0;
    if (reset_n) begin
      if (ALU_rden) begin
        e_rden = 1'b1; e_addr = ALU_read_addr;
      end else if (pend_q.size() != 0) begin
        e_rden = 1'b1; e_loc = 1'b1; e_pop = 1'b1; e_addr = pend_q[0];
      end else if (local_rden && e_ready) begin
        e_rden = 1'b1; e_loc = 1'b1; e_bypass = 1'b1; e_addr = local_read_addr;
      end
    end
    check("local_read_ready", 64'(local_read_ready), 64'(e_ready));
    check("mem_rden", 64'(mem_rden), 64'(e_rden));
    if (e_rden) check("mem_read_addr", 64'(mem_read_addr), 64'(e_addr));
    head = resp_q[0];
    check("ALU_read_valid", 64'(ALU_read_valid), 64'(reset_n && head.v && !head.loc));
    check("local_read_valid", 64'(local_read_valid), 64'(reset_n && head.v && head.loc));
    if (reset_n && head.v && !head.loc) check("ALU_read_data", 64'(ALU_read_data), 64'(ram_word(head.addr)));
    if (reset_n && head.v && head.loc) check("local_read_data", 64'(local_read_data), 64'(ram_word(head.addr)));
    if (local_read_valid) local_log.push_back(local_read_data[A-1:0]);
`ifdef READ_DEFER_STATS_EN
    check("defer_stall_count", 64'(defer_stall_count), 64'(m_stall));
    check("defer_max_occupancy", 64'(defer_max_occupancy), 64'(m_max));
`endif
    if (!reset_n) begin
      pend_q.delete();
      resp_q.delete();
      nxt = '0;
      for (int i = 0; i < L; i++) resp_q.push_back(nxt);
      m_stall = 0;
      m_max = 0;
    end else begin
      if (local_rden && !e_ready && m_stall != 16'hFFFF) m_stall++;
      if (pend_q.size() > m_max) m_max = pend_q.size();
      if (e_pop) void'(pend_q.pop_front());
      if (local_rden && e_ready && !e_bypass) pend_q.push_back(local_read_addr);
      nxt.v = e_rden;
      nxt.loc = e_loc;
      nxt.addr = e_addr;
      resp_q.push_back(nxt);
      void'(resp_q.pop_front());
    end
  end

  task automatic drive(input logic ar, input logic [A-1:0] aa, input logic lr, input logic [A-1:0] la);
    @(posedge clock);
    #1;
    ALU_rden = ar;
    ALU_read_addr = aa;
    local_rden = lr;
    local_read_addr = la;
    @(negedge clock);
  endtask

  initial begin
    int idx;
    reset_n = 1'b0;
    ALU_rden = 1'b0;
    ALU_read_addr = '0;
    local_rden = 1'b0;
    local_read_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready", 64'(local_read_ready), 64'd1);
    check("rst_mem_rden", 64'(mem_rden), 64'd0);
    check("rst_alu_valid", 64'(ALU_read_valid), 64'd0);
    check("rst_local_valid", 64'(local_read_valid), 64'd0);

    // ALU only
    drive(1, 10'h010, 0, 10'h000);
    check("alu_issue_rden", 64'(mem_rden), 64'd1);
    check("alu_issue_addr", 64'(mem_read_addr), 64'h010);
    drive(0, 10'h000, 0, 10'h000);
    check("alu_n1_valid", 64'(ALU_read_valid), 64'd0);
    drive(0, 10'h000, 0, 10'h000);
    check("alu_n2_valid", 64'(ALU_read_valid), 64'd1);
    check("alu_n2_data", 64'(ALU_read_data), 64'hA5C300010);
    check("alu_n2_local_valid", 64'(local_read_valid), 64'd0);

    // Local bypass
    drive(0, 10'h000, 1, 10'h020);
    check("byp_addr", 64'(mem_read_addr), 64'h020);
    drive(0, 10'h000, 0, 10'h000);
    drive(0, 10'h000, 0, 10'h000);
    check("byp_valid", 64'(local_read_valid), 64'd1);
    check("byp_data", 64'(local_read_data), 64'hA5C300020);

    // Collision
    drive(1, 10'h030, 1, 10'h040);
    check("col_n0_addr", 64'(mem_read_addr), 64'h030);
    drive(0, 10'h000, 0, 10'h000);
    check("col_n1_addr", 64'(mem_read_addr), 64'h040);
    drive(0, 10'h000, 0, 10'h000);
    check("col_n2_alu_valid", 64'(ALU_read_valid), 64'd1);
    check("col_n2_local_valid", 64'(local_read_valid), 64'd0);
    drive(0, 10'h000, 0, 10'h000);
    check("col_n3_local_valid", 64'(local_read_valid), 64'd1);
    check("col_n3_data", 64'(local_read_data[A-1:0]), 64'h040);

    // Full FIFO with requester holding until accepted
    drive(0, 10'h000, 0, 10'h000);
    local_log.delete();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c < 6, 10'(10'h060 + c), idx < 6, 10'(10'h100 + idx));
      if (c == 4) check("full_ready_drop", 64'(local_read_ready), 64'd0);
      if (c == 6) check("full_ready_conservative", 64'(local_read_ready), 64'd0);
      if (local_rden && local_read_ready) idx++;
    end
    check("full_all_accepted", 64'(idx), 64'd6);
    check("full_log_size", 64'(local_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < local_log.size(); i++)
      check("full_order", 64'(local_log[i]), 64'(10'h100 + i));
`ifdef READ_DEFER_STATS_EN
    check("full_max_occ", 64'(defer_max_occupancy), 64'd4);
    check("full_stall", 64'(defer_stall_count), 64'd3);
`endif

    // Reset mid-flight: three queued, two in flight
    drive(1, 10'h050, 1, 10'h300);
    drive(1, 10'h051, 1, 10'h301);
    drive(1, 10'h052, 1, 10'h302);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    ALU_rden = 1'b0;
    local_rden = 1'b0;
    @(negedge clock);
    check("rstmid_alu_valid", 64'(ALU_read_valid), 64'd0);
    drive(0, 10'h000, 1, 10'h303);
    reset_n = 1'b1;
    #1;
    check("rstmid_bypass_rden", 64'(mem_rden), 64'd1);
    check("rstmid_bypass_addr", 64'(mem_read_addr), 64'h303);
    check("rstmid_no_alu_valid", 64'(ALU_read_valid), 64'd0);
    drive(0, 10'h000, 0, 10'h000);
    check("rstmid_quiet", 64'(ALU_read_valid || local_read_valid), 64'd0);
    drive(0, 10'h000, 0, 10'h000);
    check("rstmid_byp_valid", 64'(local_read_valid), 64'd1);
    check("rstmid_byp_data", 64'(local_read_data[A-1:0]), 64'h303);

    // Push and pop in the same cycle
    drive(1, 10'h1F0, 1, 10'h200);
    drive(0, 10'h000, 1, 10'h201);
    check("pp_head_addr", 64'(mem_read_addr), 64'h200);
    check("pp_ready", 64'(local_read_ready), 64'd1);
    drive(0, 10'h000, 0, 10'h000);
    check("pp_next_rden", 64'(mem_rden), 64'd1);
    check("pp_next_addr", 64'(mem_read_addr), 64'h201);
    repeat (4) drive(0, 10'h000, 0, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
